// File: rtl/truth_table_exerciser.sv
// truth_table_exerciser: exhaustive stimulus sweep of a gate with truth-table compare
module truth_table_exerciser #(
    parameter int                  N_IN       = 2,
    parameter logic [2**N_IN-1:0]  EXP        = 4'b1000,
    parameter int                  SETTLE_CYC = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 start,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [2**N_IN-1:0]   fail_vec
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [N_IN-1:0] LAST   = N_IN'(2**N_IN - 1);
    localparam logic [7:0]      RELOAD = 8'(SETTLE_CYC - 1);
    state_t     state, state_d;
    logic [7:0] cnt;
    logic       mism;
    // case-equality so an unknown gate output is a mismatch in simulation
    assign mism = dut_out !== EXP[stim];
    assign done = state == DONE;
    // state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_d;
    end
    // next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? SETTLE : IDLE;
            SETTLE:  state_d = cnt == 8'd0 ? SAMPLE : SETTLE;
            SAMPLE:  state_d = stim == LAST ? DONE : SETTLE;
            default: state_d = IDLE;
        endcase
    end
    // stimulus, settle counter and result bookkeeping
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stim     <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
            cnt      <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    stim     <= '0;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    err_cnt  <= '0;
                    fail_vec <= '0;
                    cnt      <= RELOAD;
                end
                SETTLE: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                SAMPLE: begin
                    if (mism) begin
                        err_cnt        <= err_cnt + (N_IN+1)'(1);
                        fail_vec[stim] <= 1'b1;
                    end
                    // pass is resolved here so it is already valid in the done cycle
                    if (stim == LAST) begin
                        busy <= 1'b0;
                        pass <= err_cnt == '0 && !mism;
                    end else begin
                        stim <= stim + N_IN'(1);
                        cnt  <= RELOAD;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
